// File: rtl/adder_arbiter_if.sv
`default_nettype none
// ============================================================================
// Module      : adder_arbiter_if
// Description : Requester and result bundle for adder_arbiter. The optional
//               op_count signal exists only with ADDER_ARBITER_COUNT_EN.
// Revision    : 1.0 - initial release
// ============================================================================
interface adder_arbiter_if #(
    parameter int DATA_WIDTH = 8,
    parameter int NREQ       = 4
);
    localparam int IDW = (NREQ > 2) ? $clog2(NREQ) : 1;

    logic [NREQ-1:0]            req_valid;
    logic [NREQ*DATA_WIDTH-1:0] req_a;
    logic [NREQ*DATA_WIDTH-1:0] req_b;
    logic [NREQ-1:0]            req_ready;
    logic                       out_valid;
    logic                       out_ready;
    logic [DATA_WIDTH:0]        out_sum;
    logic [IDW-1:0]             out_id;
`ifdef ADDER_ARBITER_COUNT_EN
    logic [15:0]                op_count;
`endif

    modport master (
        output req_valid, req_a, req_b, out_ready,
        input  req_ready, out_valid, out_sum, out_id
`ifdef ADDER_ARBITER_COUNT_EN
        , input op_count
`endif
    );

    modport slave (
        input  req_valid, req_a, req_b, out_ready,
        output req_ready, out_valid, out_sum, out_id
`ifdef ADDER_ARBITER_COUNT_EN
        , output op_count
`endif
    );
endinterface
`default_nettype wire

// File: rtl/adder_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : adder_arbiter
// Description : Round-robin shared adder with a single-entry registered result.
//               Define ADDER_ARBITER_COUNT_EN to add a saturating op_count.
// Revision    : 1.0 - initial release
// ============================================================================
module adder_arbiter #(
    parameter int DATA_WIDTH = 8,
    parameter int NREQ       = 4
) (
    input  wire logic          clk,
    input  wire logic          nreset,
    adder_arbiter_if.slave     bus
);
    localparam int IDW = (NREQ > 2) ? $clog2(NREQ) : 1;

    logic                  out_valid_q, out_valid_d;
    logic [DATA_WIDTH:0]   out_sum_q,   out_sum_d;
    logic [IDW-1:0]        out_id_q,    out_id_d;
    logic [IDW-1:0]        rr_ptr_q,    rr_ptr_d;

    logic                  w_load;
    logic                  w_found;
    logic                  w_xfer;
    logic [IDW-1:0]        w_grant;
    logic [DATA_WIDTH-1:0] w_a;
    logic [DATA_WIDTH-1:0] w_b;
    logic [DATA_WIDTH:0]   w_sum;
    logic [NREQ-1:0]       w_ready;

    // Gating with nreset keeps every req_ready low while reset is applied.
    assign w_load = nreset & (~out_valid_q | bus.out_ready);
    assign w_xfer = w_load & w_found;

    always_comb begin
        logic [IDW:0]   idx;
        logic [IDW-1:0] idx_t;
        w_found = 1'b0;
        w_grant = '0;
        idx     = '0;
        idx_t   = '0;
        for (int k = 0; k < NREQ; k++) begin
            idx = {1'b0, rr_ptr_q} + (IDW+1)'(k);
            if (idx >= (IDW+1)'(NREQ)) begin
                idx = idx - (IDW+1)'(NREQ);
            end
            idx_t = idx[IDW-1:0];
            if (!w_found && bus.req_valid[idx_t]) begin
                w_found = 1'b1;
                w_grant = idx_t;
            end
        end
    end

    always_comb begin
        w_a = '0;
        w_b = '0;
        for (int i = 0; i < NREQ; i++) begin
            if (w_grant == IDW'(i)) begin
                w_a = bus.req_a[i*DATA_WIDTH +: DATA_WIDTH];
                w_b = bus.req_b[i*DATA_WIDTH +: DATA_WIDTH];
            end
        end
    end

    assign w_sum = {1'b0, w_a} + {1'b0, w_b};

    always_comb begin
        w_ready = '0;
        if (w_xfer) begin
            w_ready[w_grant] = 1'b1;
        end
    end

    always_comb begin
        out_valid_d = out_valid_q;
        out_sum_d   = out_sum_q;
        out_id_d    = out_id_q;
        rr_ptr_d    = rr_ptr_q;
        if (w_xfer) begin
            out_valid_d = 1'b1;
            out_sum_d   = w_sum;
            out_id_d    = w_grant;
            rr_ptr_d    = (w_grant == IDW'(NREQ-1)) ? '0 : w_grant + IDW'(1);
        end else if (bus.out_ready) begin
            out_valid_d = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (!nreset) begin
            out_valid_q <= 1'b0;
            out_sum_q   <= '0;
            out_id_q    <= '0;
            rr_ptr_q    <= '0;
        end else begin
            out_valid_q <= out_valid_d;
            out_sum_q   <= out_sum_d;
            out_id_q    <= out_id_d;
            rr_ptr_q    <= rr_ptr_d;
        end
    end

    assign bus.req_ready = w_ready;
    assign bus.out_valid = out_valid_q;
    assign bus.out_sum   = out_sum_q;
    assign bus.out_id    = out_id_q;

`ifdef ADDER_ARBITER_COUNT_EN
    logic [15:0] op_count_q, op_count_d;

    always_comb begin
        op_count_d = op_count_q;
        if (w_xfer && (op_count_q != 16'hFFFF)) begin
            op_count_d = op_count_q + 16'd1;
        end
    end

    always_ff @(posedge clk) begin
        if (!nreset) begin
            op_count_q <= '0;
        end else begin
            op_count_q <= op_count_d;
        end
    end

    assign bus.op_count = op_count_q;
`endif
endmodule
`default_nettype wire

// File: tb/tb_adder_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : tb_adder_arbiter
// Description : Directed bench for adder_arbiter with a result scoreboard.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_adder_arbiter;
    localparam int DW   = 8;
    localparam int NREQ = 4;
    localparam int IDW  = 2;

    typedef struct packed {
        logic [DW:0]    sum;
        logic [IDW-1:0] id;
    } res_t;

    logic clk = 1'b0;
    logic nreset = 1'b0;
    always #5 clk = ~clk;

    adder_arbiter_if #(.DATA_WIDTH(DW), .NREQ(NREQ)) bus ();

    adder_arbiter #(.DATA_WIDTH(DW), .NREQ(NREQ)) dut (
        .clk    (clk),
        .nreset (nreset),
        .bus    (bus)
    );

    logic [DW-1:0]   op_a [NREQ];
    logic [DW-1:0]   op_b [NREQ];
    logic [NREQ-1:0] valid;
    logic            ordy;

    res_t sb[$];
    int   grants[$];
    int   checks = 0;
    int   errors = 0;
    int   m_rr   = 0;
    bit   m_ov   = 1'b0;
    int   m_cnt  = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic drive();
        for (int i = 0; i < NREQ; i++) begin
            bus.req_a[i*DW +: DW] = op_a[i];
            bus.req_b[i*DW +: DW] = op_b[i];
        end
        bus.req_valid = valid;
        bus.out_ready = ordy;
    endtask

    // One clock: check handshake against the model, pop/push the scoreboard.
    task automatic cycle();
        logic [NREQ-1:0] exp_rdy;
        int   g;
        int   idx;
        res_t e;
        drive();
        #1;
        exp_rdy = '0;
        g = -1;
        if (nreset && (!m_ov || ordy)) begin
            for (int k = 0; k < NREQ; k++) begin
                idx = (m_rr + k) % NREQ;
                if (g < 0 && valid[idx]) g = idx;
            end
        end
        if (g >= 0) exp_rdy[g] = 1'b1;
        chk("req_ready", 32'(bus.req_ready), 32'(exp_rdy));
        chk("out_valid", 32'(bus.out_valid), 32'(m_ov));
        if (nreset && m_ov && ordy) begin
            if (sb.size() == 0) begin
                chk("sb_empty_pop", 32'd1, 32'd0);
            end else begin
                e = sb.pop_front();
                chk("sb_sum", 32'(bus.out_sum), 32'(e.sum));
                chk("sb_id", 32'(bus.out_id), 32'(e.id));
            end
        end
        @(posedge clk);
        if (!nreset) begin
            m_ov = 1'b0;
            m_rr = 0;
            m_cnt = 0;
            sb.delete();
        end else if (g >= 0) begin
            e.sum = (DW+1)'(op_a[g]) + (DW+1)'(op_b[g]);
            e.id  = IDW'(g);
            sb.push_back(e);
            grants.push_back(g);
            m_rr = (g + 1) % NREQ;
            m_ov = 1'b1;
            if (m_cnt < 16'hFFFF) m_cnt++;
        end else if (ordy) begin
            m_ov = 1'b0;
        end
        @(negedge clk);
`ifdef ADDER_ARBITER_COUNT_EN
        chk("op_count", 32'(bus.op_count), 32'(m_cnt));
`endif
    endtask

    initial begin
        int exp_order [6];
        exp_order = '{0, 1, 2, 3, 0, 1};
        for (int i = 0; i < NREQ; i++) begin
            op_a[i] = DW'(10 * i + 1);
            op_b[i] = DW'(i + 5);
        end
        valid = '1;
        ordy  = 1'b1;
        nreset = 1'b0;
        drive();
        @(posedge clk);
        @(negedge clk);

        // Reset held with every requester valid
        repeat (2) begin
            cycle();
            chk("rst_out_valid", 32'(bus.out_valid), 32'd0);
            chk("rst_out_sum", 32'(bus.out_sum), 32'd0);
            chk("rst_out_id", 32'(bus.out_id), 32'd0);
        end

        // Round robin with continuous drain
        nreset = 1'b1;
        grants.delete();
        repeat (6) cycle();
        chk("rr_count", 32'(grants.size()), 32'd6);
        for (int i = 0; i < 6 && i < grants.size(); i++) begin
            chk($sformatf("rr_order%0d", i), 32'(grants[i]), 32'(exp_order[i]));
        end
        valid = '0;
        repeat (2) cycle();

        // Single requester
        op_a[2] = 8'd100;
        op_b[2] = 8'd27;
        valid   = 4'b0100;
        cycle();
        valid = '0;
        chk("single_valid", 32'(bus.out_valid), 32'd1);
        chk("single_sum", 32'(bus.out_sum), 32'd127);
        chk("single_id", 32'(bus.out_id), 32'd2);
        repeat (2) cycle();

        // Backpressure with requests pending
        valid = '1;
        cycle();
        ordy = 1'b0;
        repeat (5) begin
            cycle();
            chk("bp_sum_stable", 32'(bus.out_sum), 32'(sb[0].sum));
            chk("bp_id_stable", 32'(bus.out_id), 32'(sb[0].id));
        end
        ordy = 1'b1;
        grants.delete();
        cycle();
        chk("bp_regrant", 32'(grants.size()), 32'd1);
        chk("bp_valid_after", 32'(bus.out_valid), 32'd1);
        valid = '0;
        repeat (2) cycle();

        // Overflow at index NREQ-1, then wrap to requester 0
        op_a[3] = 8'hFF;
        op_b[3] = 8'hFF;
        valid   = 4'b1000;
        cycle();
        valid = '0;
        chk("ovf_sum", 32'(bus.out_sum), 32'd510);
        chk("ovf_id", 32'(bus.out_id), 32'd3);
        op_a[0] = 8'd3;
        op_b[0] = 8'd4;
        valid   = 4'b1001;
        grants.delete();
        cycle();
        chk("wrap_winner", 32'((grants.size() > 0) ? grants[0] : -1), 32'd0);
        valid = '0;
        repeat (2) cycle();

        // Reset while a result is held
        valid = 4'b0010;
        ordy  = 1'b0;
        cycle();
        valid = '0;
        chk("mid_held", 32'(bus.out_valid), 32'd1);
        nreset = 1'b0;
        cycle();
        chk("mid_rst_valid", 32'(bus.out_valid), 32'd0);
        chk("mid_rst_sum", 32'(bus.out_sum), 32'd0);
        nreset = 1'b1;
        ordy   = 1'b1;
        repeat (2) cycle();
        chk("final_sb_empty", 32'(sb.size()), 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
`default_nettype wire
